// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register placed right after the register bank.
//  - Captures bank read data into the ID/EX register. Write-back data that lands in the
//    same cycle is bypassed in, because the bank writes on the edge but reads
//    combinationally.
//  - Detects load-use hazards. It holds the front end via `stall` for LOAD_STALL_CYCLES
//    cycles and inserts one bubble per stalled cycle.
//  - A branch flush kills the ID instruction and cancels any stall in progress.
// Ports:
//  clock, reset (async, active-low)
//  flush, id_*           : ID-slot instruction fields and control
//  rd1_in, rd2_in        : bank read data
//  wb_*                  : bank write port, used for bypassing
//  stall                 : combinational front-end hold
//  ex_*                  : registered ID/EX contents
module id_ex_stage #(
  parameter int unsigned addr_bits         = 5,
  parameter int unsigned word_wide         = 32,
  parameter int unsigned CTRL_W            = 8,
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [addr_bits-1:0] id_rs,
  input  logic [addr_bits-1:0] id_rt,
  input  logic [addr_bits-1:0] id_rd,
  input  logic                 id_regDst,
  input  logic                 id_memRead,
  input  logic                 id_regWrite,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic [word_wide-1:0] id_imm,
  input  logic [word_wide-1:0] rd1_in,
  input  logic [word_wide-1:0] rd2_in,
  input  logic                 wb_regWrite,
  input  logic [addr_bits-1:0] wb_writeReg,
  input  logic [word_wide-1:0] wb_writeData,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [addr_bits-1:0] ex_rs,
  output logic [addr_bits-1:0] ex_rt,
  output logic [addr_bits-1:0] ex_dst,
  output logic                 ex_memRead,
  output logic                 ex_regWrite,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic [word_wide-1:0] ex_data1,
  output logic [word_wide-1:0] ex_data2,
  output logic [word_wide-1:0] ex_imm
);

  localparam int unsigned CntW = $clog2(LOAD_STALL_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StStall = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 stall_c;
  logic                 hazard;
  logic [word_wide-1:0] d1, d2;

  logic                 ex_valid_q, ex_memRead_q, ex_regWrite_q;
  logic [addr_bits-1:0] ex_rs_q, ex_rt_q, ex_dst_q;
  logic [CTRL_W-1:0]    ex_ctrl_q;
  logic [word_wide-1:0] ex_data1_q, ex_data2_q, ex_imm_q;

  // Same-cycle write-back bypass. Register 0 is an ordinary register in this bank.
  always_comb begin
    d1 = (wb_regWrite && (wb_writeReg == id_rs)) ? wb_writeData : rd1_in;
    d2 = (wb_regWrite && (wb_writeReg == id_rt)) ? wb_writeData : rd2_in;
  end

  // A load in EX whose destination is read by the ID instruction.
  always_comb begin
    hazard = id_valid & ex_valid_q & ex_memRead_q &
             ((ex_dst_q == id_rs) | (ex_dst_q == id_rt));
  end

  // The first stalled cycle is spent in StRun (detected hazard). StStall covers the
  // remaining LOAD_STALL_CYCLES-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      StRun: begin
        stall_c = hazard & ~flush;
        if (hazard && !flush && (LOAD_STALL_CYCLES > 1)) begin
          state_d = StStall;
          cnt_d   = CntLoad;
        end
      end
      StStall: begin
        stall_c = ~flush;
        cnt_d   = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    if (flush) begin
      state_d = StRun;
      cnt_d   = '0;
    end
  end

  assign stall = stall_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      cnt_q         <= '0;
      ex_valid_q    <= 1'b0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_dst_q      <= '0;
      ex_memRead_q  <= 1'b0;
      ex_regWrite_q <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_data1_q    <= '0;
      ex_data2_q    <= '0;
      ex_imm_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (flush || stall_c || !id_valid) begin
        // Bubble
        ex_valid_q    <= 1'b0;
        ex_rs_q       <= '0;
        ex_rt_q       <= '0;
        ex_dst_q      <= '0;
        ex_memRead_q  <= 1'b0;
        ex_regWrite_q <= 1'b0;
        ex_ctrl_q     <= '0;
        ex_data1_q    <= '0;
        ex_data2_q    <= '0;
        ex_imm_q      <= '0;
      end else begin
        ex_valid_q    <= 1'b1;
        ex_rs_q       <= id_rs;
        ex_rt_q       <= id_rt;
        ex_dst_q      <= id_regDst ? id_rd : id_rt;
        ex_memRead_q  <= id_memRead;
        ex_regWrite_q <= id_regWrite;
        ex_ctrl_q     <= id_ctrl;
        ex_data1_q    <= d1;
        ex_data2_q    <= d2;
        ex_imm_q      <= id_imm;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_dst      = ex_dst_q;
  assign ex_memRead  = ex_memRead_q;
  assign ex_regWrite = ex_regWrite_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_data1    = ex_data1_q;
  assign ex_data2    = ex_data2_q;
  assign ex_imm      = ex_imm_q;

endmodule
